gray_position_tracker: RTL and testbench

GRAY_POSITION_TRACKER -- requirements
Module: gray_position_tracker

---
 rtl/gray_position_tracker_pkg.sv | 14 +
 rtl/gray_position_tracker_g2b.sv | 25 ++
 rtl/gray_position_tracker.sv | 170 +++++++++++++++++
 tb/tb_gray_position_tracker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gray_position_tracker_pkg.sv
// Shared definitions for the gray position tracker.
// Holds the tracking FSM state type and the error counter width.
package gray_position_tracker_pkg;

  // Width of the saturating illegal-jump counter.
  localparam int ERR_CNT_W = 8;

  // UNLOCKED: no code accepted yet. TRACK: following single-bit steps.
  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    TRACK    = 1'b1
  } track_state_e;

endpackage

// File: rtl/gray_position_tracker_g2b.sv
// Combinational gray-to-binary converter.
// Ports:
//   gray   - gray-coded input, WIDTH bits
//   binary - binary equivalent, WIDTH bits (MSB copied, each lower bit
//            is the XOR of the binary bit above and the gray bit)
module g2b_converter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] binary
);

  // Prefix XOR from the MSB downwards.
  always_comb begin
    logic acc;
    binary = {WIDTH{1'b0}};
    acc    = gray[WIDTH-1];
    binary[WIDTH-1] = acc;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      acc       = acc ^ gray[i];
      binary[i] = acc;
    end
  end

endmodule

// File: rtl/gray_position_tracker.sv
// Gray-coded position tracker.
// Synchronizes an asynchronous gray position, filters it until it has been
// stable for STABLE_CYCLES samples, then reports single-bit steps with
// direction or flags illegal multi-bit jumps.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   gray       - asynchronous gray-coded position
//   err_clr    - synchronous clear of err_cnt (wins over a coincident err)
//   binary     - binary position of the last accepted code
//   locked     - high once a first code has been accepted
//   step_valid - one-cycle pulse on a legal single-bit step
//   step_up    - step direction (1 = up), qualified by step_valid
//   err        - one-cycle pulse on an illegal multi-bit jump
//   err_cnt    - saturating count of err pulses
module gray_position_tracker
  import gray_position_tracker_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     binary,
  output logic                 locked,
  output logic                 step_valid,
  output logic                 step_up,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  // The counter is cleared on the first sample of a new candidate, so it
  // holds (identical samples - 1); S samples are complete at S-1.
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [1:0]       fill;        // marks s1/s2 holding real samples after reset
  logic [WIDTH-1:0] cand;
  logic             cand_valid;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] last_code;
  track_state_e     state;

  logic             sampling;
  logic             diff;
  logic [WIDTH-1:0] cand_next;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] code_xor;
  logic             dist_zero;
  logic             dist_one;
  logic             err_fire;

  assign sampling = fill[1];
  // An empty candidate after reset counts as a difference so the first real
  // sample always starts a fresh stability window, even for code zero.
  assign diff     = !cand_valid || (s2 != cand);

  // Stability filter next-state and accept decision.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    accept    = 1'b0;
    if (sampling) begin
      if (diff) begin
        cand_next = s2;
        cnt_next  = {CNT_W{1'b0}};
      end else begin
        cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      end
      accept = (cnt_next == CNT_FIRE) && (diff || (cnt != CNT_FIRE));
    end else begin
      accept = 1'b0;
    end
  end

  g2b_converter #(.WIDTH(WIDTH)) u_g2b (
    .gray   (cand_next),
    .binary (new_bin)
  );

  // Hamming distance class between the accepted and previous codes.
  assign code_xor  = cand_next ^ last_code;
  assign dist_zero = (code_xor == {WIDTH{1'b0}});
  assign dist_one  = !dist_zero && ((code_xor & (code_xor - W_ONE)) == {WIDTH{1'b0}});
  assign err_fire  = accept && (state == TRACK) && !dist_zero && !dist_one;

  // Input synchronizer and candidate/stability registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= {WIDTH{1'b0}};
      s2         <= {WIDTH{1'b0}};
      fill       <= 2'b00;
      cand       <= {WIDTH{1'b0}};
      cand_valid <= 1'b0;
      cnt        <= {CNT_W{1'b0}};
    end else begin
      s1         <= gray;
      s2         <= s1;
      fill       <= {fill[0], 1'b1};
      cand       <= cand_next;
      cand_valid <= cand_valid | sampling;
      cnt        <= cnt_next;
    end
  end

  // Tracking FSM with registered position and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= UNLOCKED;
      binary     <= {WIDTH{1'b0}};
      last_code  <= {WIDTH{1'b0}};
      locked     <= 1'b0;
      step_valid <= 1'b0;
      step_up    <= 1'b0;
      err        <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        UNLOCKED: begin
          if (accept) begin
            binary    <= new_bin;
            last_code <= cand_next;
            locked    <= 1'b1;
            state     <= TRACK;
          end
        end
        TRACK: begin
          // A code that returns to the last accepted one is not a move.
          if (accept && !dist_zero) begin
            binary    <= new_bin;
            last_code <= cand_next;
            if (dist_one) begin
              step_valid <= 1'b1;
              step_up    <= (new_bin == binary + W_ONE);
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter; clear has priority over a coincident error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= {ERR_CNT_W{1'b0}};
    end else if (err_clr) begin
      err_cnt <= {ERR_CNT_W{1'b0}};
    end else if (err_fire && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_gray_position_tracker.sv
// Scoreboard bench for gray_position_tracker (WIDTH=4, STABLE_CYCLES=3).
module tb_gray_position_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray;
  logic       err_clr;
  logic [3:0] binary;
  logic       locked;
  logic       step_valid;
  logic       step_up;
  logic       err;
  logic [7:0] err_cnt;

  localparam int K_LOCK = 0;
  localparam int K_STEP = 1;
  localparam int K_ERR  = 2;
  localparam int K_NONE = -1;

  typedef struct {
    int         kind;
    logic [3:0] bin;
    logic       up;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  gray_position_tracker #(.WIDTH(4), .STABLE_CYCLES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .gray       (gray),
    .err_clr    (err_clr),
    .binary     (binary),
    .locked     (locked),
    .step_valid (step_valid),
    .step_up    (step_up),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [3:0] bin, input logic up, input logic [7:0] cnt);
    exp_t e;
    e.kind = kind;
    e.bin  = bin;
    e.up   = up;
    e.cnt  = cnt;
    q.push_back(e);
  endtask

  // Drive a new code, register what should come out, and wait it out.
  // With clr_at_fire, err_clr is high exactly on the accept edge (edge 5).
  task automatic apply(input logic [3:0] code, input int kind, input logic [3:0] bin,
                       input logic up, input logic [7:0] cnt, input bit clr_at_fire);
    @(negedge clk);
    gray = code;
    if (kind != K_NONE) expect_ev(kind, bin, up, cnt);
    repeat (4) @(posedge clk);
    #1 err_clr = clr_at_fire;
    @(posedge clk);
    #1 err_clr = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the DUT reports an event.
  initial begin
    logic prev_locked;
    int   act_kind;
    exp_t e;
    prev_locked = 1'b0;
    forever begin
      @(negedge clk);
      if (step_valid && err) check("step_err_exclusive", 32'd1, 32'd0);
      if ((locked && !prev_locked) || step_valid || err) begin
        act_kind = (locked && !prev_locked) ? K_LOCK : (step_valid ? K_STEP : K_ERR);
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got kind %0d binary %0h, expected none at %0t",
                   act_kind, binary, $time);
        end else begin
          e = q.pop_front();
          check("ev_kind", act_kind, e.kind);
          check("ev_binary", {28'd0, binary}, {28'd0, e.bin});
          if (e.kind == K_STEP) check("ev_step_up", {31'd0, step_up}, {31'd0, e.up});
          if (e.kind == K_ERR)  check("ev_err_cnt", {24'd0, err_cnt}, {24'd0, e.cnt});
        end
      end
      prev_locked = locked;
    end
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    gray    = 4'b0110;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_binary", {28'd0, binary}, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    expect_ev(K_LOCK, 4'b0100, 1'b0, 8'd0);
    repeat (4) @(posedge clk);
    #1 check("lock_not_before_edge5", {31'd0, locked}, 32'd0);
    @(posedge clk);
    #1;
    check("lock_edge5_locked", {31'd0, locked}, 32'd1);
    check("lock_edge5_binary", {28'd0, binary}, 32'd4);
    check("lock_edge5_no_step", {31'd0, step_valid}, 32'd0);
    check("lock_edge5_no_err", {31'd0, err}, 32'd0);
    repeat (4) @(posedge clk);

    apply(4'b0111, K_STEP, 4'b0101, 1'b1, 8'd0, 1'b0);  // 4 -> 5 up
    apply(4'b1000, K_ERR,  4'b1111, 1'b0, 8'd1, 1'b0);  // 4-bit jump to 15
    apply(4'b0000, K_STEP, 4'b0000, 1'b1, 8'd0, 1'b0);  // wrap 15 -> 0 up
    apply(4'b1000, K_STEP, 4'b1111, 1'b0, 8'd0, 1'b0);  // wrap 0 -> 15 down
    apply(4'b0000, K_STEP, 4'b0000, 1'b1, 8'd0, 1'b0);

    // Two-sample glitch must be filtered out completely.
    @(negedge clk);
    gray = 4'b0001;
    repeat (2) @(negedge clk);
    gray = 4'b0000;
    repeat (8) @(negedge clk);
    check("glitch_binary", {28'd0, binary}, 32'd0);

    pulse_clr();
    @(negedge clk);
    check("clr_err_cnt", {24'd0, err_cnt}, 32'd0);

    apply(4'b0011, K_ERR, 4'b0010, 1'b0, 8'd1, 1'b0);   // illegal jump, 0 -> 2
    for (int i = 2; i <= 300; i++) begin
      if (i % 2 == 0) apply(4'b0000, K_ERR, 4'b0000, 1'b0, (i > 255) ? 8'd255 : 8'(i), 1'b0);
      else            apply(4'b0011, K_ERR, 4'b0010, 1'b0, (i > 255) ? 8'd255 : 8'(i), 1'b0);
    end
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
    apply(4'b0011, K_ERR, 4'b0010, 1'b0, 8'd0, 1'b1);   // clear coincides with err
    apply(4'b0000, K_ERR, 4'b0000, 1'b0, 8'd1, 1'b0);
    pulse_clr();
    @(negedge clk);
    check("clr_after_sat", {24'd0, err_cnt}, 32'd0);

    // Reset two edges into a pending step: discard it, relock cleanly.
    @(negedge clk);
    gray = 4'b0001;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_binary", {28'd0, binary}, 32'd0);
    check("midrst_locked", {31'd0, locked}, 32'd0);
    check("midrst_step", {30'd0, step_valid, step_up}, 32'd0);
    check("midrst_err", {23'd0, err, err_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_ev(K_LOCK, 4'b0001, 1'b0, 8'd0);
    repeat (5) @(posedge clk);
    #1;
    check("relock_locked", {31'd0, locked}, 32'd1);
    check("relock_binary", {28'd0, binary}, 32'd1);
    repeat (6) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
